// File: rtl/ampel_pkg.sv
// ampel_pkg: phase encoding, lamp bundle and default phase durations
// shared by the ampel_ctrl_n traffic-light controller slice.
package ampel_pkg;

  typedef enum logic [2:0] {
    RGELB,
    GRUEN,
    GELB,
    ALLROT,
    NACHT
  } phase_e;

  typedef struct packed {
    logic rt;
    logic ge;
    logic gr;
  } lamp_t;

  localparam int NUM_DIR_DEF  = 2;
  localparam int CNT_W_DEF    = 5;
  localparam int T_RGELB_DEF  = 2;
  localparam int T_GRUEN_DEF  = 15;
  localparam int T_GELB_DEF   = 3;
  localparam int T_ALLROT_DEF = 2;
  localparam int T_FUSS_DEF   = 5;

endpackage

// File: rtl/ampel_timer.sv
// ampel_timer: loadable phase interval counter, decremented on tick,
// holds at zero and flags it.
module ampel_timer #(
  parameter int CNT_W   = 5,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  assign zero = (value == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value <= CNT_W'(RST_VAL);
    end else if (load) begin
      value <= load_val;
    end else if (tick && !zero) begin
      value <= value - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ampel_ctrl_n.sv
// ampel_ctrl_n: round-robin N-direction traffic lights with pedestrian
// requests; night blinking is built only with AMPEL_NACHT_EN defined.
module ampel_ctrl_n
  import ampel_pkg::*;
#(
  parameter int NUM_DIR  = NUM_DIR_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int T_RGELB  = T_RGELB_DEF,
  parameter int T_GRUEN  = T_GRUEN_DEF,
  parameter int T_GELB   = T_GELB_DEF,
  parameter int T_ALLROT = T_ALLROT_DEF,
  parameter int T_FUSS   = T_FUSS_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tick,
  input  logic [NUM_DIR-1:0]         f_an,
  input  logic                       nacht,
  output logic [NUM_DIR-1:0]         rt,
  output logic [NUM_DIR-1:0]         ge,
  output logic [NUM_DIR-1:0]         gr,
  output logic [NUM_DIR-1:0]         f_rt,
  output logic [NUM_DIR-1:0]         f_gr,
  output logic [NUM_DIR-1:0]         f_sg,
  output logic [$clog2(NUM_DIR)-1:0] dir
);

  localparam int DW    = $clog2(NUM_DIR);
  localparam int T_MIN = (T_GRUEN < T_FUSS) ? T_GRUEN : T_FUSS;

  localparam logic [CNT_W-1:0] LD_RGELB  = CNT_W'(T_RGELB - 1);
  localparam logic [CNT_W-1:0] LD_GRUEN  = CNT_W'(T_GRUEN - 1);
  localparam logic [CNT_W-1:0] LD_GELB   = CNT_W'(T_GELB - 1);
  localparam logic [CNT_W-1:0] LD_ALLROT = CNT_W'(T_ALLROT - 1);
  localparam logic [CNT_W-1:0] LD_FUSS   = CNT_W'(T_FUSS - 1);
  localparam logic [CNT_W-1:0] LD_SHORT  = CNT_W'(T_MIN - 1);

  phase_e             phase, phase_n;
  logic [DW-1:0]      dir_n;
  logic [NUM_DIR-1:0] req, req_n;
  logic               tload;
  logic [CNT_W-1:0]   tval;
  logic [CNT_W-1:0]   timer;
  logic               tzero;
  logic               adv;
  logic               fg_c, fg_n;
  lamp_t              lp;

`ifdef AMPEL_NACHT_EN
  logic blink, blink_n;
`else
  logic unused_nacht;
  assign unused_nacht = nacht;
`endif

  ampel_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(T_ALLROT - 1)
  ) u_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .load    (tload),
    .load_val(tval),
    .value   (timer),
    .zero    (tzero)
  );

  assign adv = tick && tzero;

  always_comb begin
    phase_n = phase;
    dir_n   = dir;
    tload   = 1'b0;
    tval    = timer;
    req_n   = req;
    fg_c    = 1'b0;
    fg_n    = 1'b0;
`ifdef AMPEL_NACHT_EN
    blink_n = blink;
`endif
    unique case (1'b1)
      (phase == RGELB): if (adv) begin
        phase_n = GRUEN;
        tload   = 1'b1;
        tval    = req[dir] ? LD_SHORT : LD_GRUEN;
      end
      (phase == GRUEN): begin
        // shortening wins over a same-cycle tick decrement
        if (req[dir] && timer > LD_FUSS) begin
          tload = 1'b1;
          tval  = LD_FUSS;
        end else if (adv) begin
          phase_n = GELB;
          tload   = 1'b1;
          tval    = LD_GELB;
        end
      end
      (phase == GELB): if (adv) begin
        phase_n = ALLROT;
        tload   = 1'b1;
        tval    = LD_ALLROT;
      end
      (phase == ALLROT): if (adv) begin
        phase_n = RGELB;
        dir_n   = (dir == DW'(NUM_DIR - 1)) ? '0 : dir + DW'(1);
        tload   = 1'b1;
        tval    = LD_RGELB;
`ifdef AMPEL_NACHT_EN
        if (nacht) begin
          phase_n = NACHT;
          dir_n   = dir;
          tload   = 1'b0;
          tval    = timer;
          blink_n = 1'b1;
        end
`endif
      end
`ifdef AMPEL_NACHT_EN
      (phase == NACHT): if (tick) begin
        if (!nacht) begin
          phase_n = ALLROT;
          dir_n   = DW'(NUM_DIR - 1);
          tload   = 1'b1;
          tval    = LD_ALLROT;
        end else begin
          blink_n = ~blink;
        end
      end
`endif
      default: ;
    endcase
    // requests clear on the edge that raises the crossing's green
    for (int d = 0; d < NUM_DIR; d++) begin
      fg_c = (phase == GRUEN) && (dir != DW'(d));
      fg_n = (phase_n == GRUEN) && (dir_n != DW'(d));
      if (fg_n) begin
        req_n[d] = 1'b0;
      end else if (f_an[d] && !fg_c && phase != NACHT) begin
        req_n[d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= ALLROT;
      dir   <= DW'(NUM_DIR - 1);
      req   <= '0;
    end else begin
      phase <= phase_n;
      dir   <= dir_n;
      req   <= req_n;
    end
  end

`ifdef AMPEL_NACHT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink <= 1'b0;
    end else begin
      blink <= blink_n;
    end
  end
`endif

  always_comb begin
    rt   = '0;
    ge   = '0;
    gr   = '0;
    f_rt = '0;
    f_gr = '0;
    f_sg = '0;
    lp   = '{rt: 1'b1, ge: 1'b0, gr: 1'b0};
    for (int d = 0; d < NUM_DIR; d++) begin
      lp = '{rt: 1'b1, ge: 1'b0, gr: 1'b0};
      if (dir == DW'(d)) begin
        unique case (phase)
          RGELB:   lp = '{rt: 1'b1, ge: 1'b1, gr: 1'b0};
          GRUEN:   lp = '{rt: 1'b0, ge: 1'b0, gr: 1'b1};
          GELB:    lp = '{rt: 1'b0, ge: 1'b1, gr: 1'b0};
          default: ;
        endcase
      end
      rt[d]   = lp.rt;
      ge[d]   = lp.ge;
      gr[d]   = lp.gr;
      f_gr[d] = (phase == GRUEN) && (dir != DW'(d));
      f_rt[d] = !f_gr[d];
      f_sg[d] = req[d];
`ifdef AMPEL_NACHT_EN
      if (phase == NACHT) begin
        rt[d]   = 1'b0;
        ge[d]   = blink;
        gr[d]   = 1'b0;
        f_rt[d] = 1'b0;
        f_gr[d] = 1'b0;
        f_sg[d] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ampel_ctrl_n.sv
// tb_ampel_ctrl_n: directed phase-timing scenarios plus random ticks and
// requests, checked each cycle against a remaining-ticks reference model.
module tb_ampel_ctrl_n;

  localparam int N  = 2;
  localparam int CW = 5;
  localparam int TR = 2;
  localparam int TG = 15;
  localparam int TY = 3;
  localparam int TA = 2;
  localparam int TF = 5;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         tick = 1'b0;
  logic         nacht = 1'b0;
  logic [N-1:0] f_an = '0;
  logic [N-1:0] rt, ge, gr, f_rt, f_gr, f_sg;
  logic [0:0]   dir;

  int n_run = 0;
  int n_fail = 0;

  // reference model: phase 0..3 = RGELB,GRUEN,GELB,ALLROT, 4 = night;
  // m_rem counts ticks still to go in the phase (1 = last tick)
  int     m_ph, m_dir, m_rem;
  bit     m_blink;
  bit [N-1:0] m_req;
  int     gcnt[N];
  int     glen[N];

  ampel_ctrl_n #(
    .NUM_DIR (N),
    .CNT_W   (CW),
    .T_RGELB (TR),
    .T_GRUEN (TG),
    .T_GELB  (TY),
    .T_ALLROT(TA),
    .T_FUSS  (TF)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick),
    .f_an   (f_an),
    .nacht  (nacht),
    .rt     (rt),
    .ge     (ge),
    .gr     (gr),
    .f_rt   (f_rt),
    .f_gr   (f_gr),
    .f_sg   (f_sg),
    .dir    (dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return 32'({rt, ge, gr, f_rt, f_gr, f_sg, dir});
  endfunction

  function automatic logic [31:0] expv();
    logic [N-1:0] e_rt, e_ge, e_gr, e_frt, e_fgr, e_sg;
    bit act;
    e_rt = '0; e_ge = '0; e_gr = '0;
    e_frt = '0; e_fgr = '0; e_sg = '0;
    for (int d = 0; d < N; d++) begin
      act = (d == m_dir);
      if (m_ph == 4) begin
        e_ge[d] = m_blink;
      end else begin
        e_rt[d]  = !act || m_ph == 0 || m_ph == 3;
        e_ge[d]  = act && (m_ph == 0 || m_ph == 2);
        e_gr[d]  = act && m_ph == 1;
        e_fgr[d] = !act && m_ph == 1;
        e_frt[d] = !e_fgr[d];
        e_sg[d]  = m_req[d];
      end
    end
    return 32'({e_rt, e_ge, e_gr, e_frt, e_fgr, e_sg, 1'(m_dir)});
  endfunction

  task automatic model_reset();
    m_ph = 3; m_dir = N - 1; m_rem = TA; m_req = '0; m_blink = 0;
    for (int d = 0; d < N; d++) begin
      gcnt[d] = 0;
      glen[d] = 0;
    end
  endtask

  task automatic model_step(input bit tk, input logic [N-1:0] fa,
                            input bit nt);
    int nph, ndir, nrem;
    bit [N-1:0] nreq;
    bit night_en;
    nph = m_ph; ndir = m_dir; nrem = m_rem;
`ifdef AMPEL_NACHT_EN
    night_en = 1;
`else
    night_en = 0;
`endif
    if (m_ph == 4) begin
      if (tk) begin
        if (!nt) begin
          nph = 3; ndir = N - 1; nrem = TA;
        end else begin
          m_blink = !m_blink;
        end
      end
    end else if (m_ph == 1 && m_req[m_dir] && m_rem > TF) begin
      nrem = TF;
    end else if (tk) begin
      if (m_rem > 1) begin
        nrem = m_rem - 1;
      end else begin
        case (m_ph)
          0: begin nph = 1; nrem = m_req[m_dir] ? ((TG < TF) ? TG : TF) : TG; end
          1: begin nph = 2; nrem = TY; end
          2: begin nph = 3; nrem = TA; end
          default: begin
            if (night_en && nt) begin
              nph = 4; m_blink = 1;
            end else begin
              nph = 0; ndir = (m_dir + 1) % N; nrem = TR;
            end
          end
        endcase
      end
    end
    for (int d = 0; d < N; d++) begin
      if (nph == 1 && ndir != d) nreq[d] = 0;
      else nreq[d] = m_req[d] | (fa[d] && !(m_ph == 1 && m_dir != d) && m_ph != 4);
    end
    m_ph = nph; m_dir = ndir; m_rem = nrem; m_req = nreq;
  endtask

  // one clock: drive inputs at negedge, advance model, compare at next negedge
  task automatic cyc(input bit tk, input logic [N-1:0] fa, input bit nt);
    logic [N-1:0] pre_gr;
    tick = tk; f_an = fa; nacht = nt;
    pre_gr = gr;
    if (tk) begin
      for (int d = 0; d < N; d++) if (gr[d]) gcnt[d]++;
    end
    model_step(tk, fa, nt);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      if (pre_gr[d] && !gr[d]) begin
        glen[d] = gcnt[d];
        gcnt[d] = 0;
      end
    end
    check("cyc", obs(), expv());
    tick = 1'b0; f_an = '0;
  endtask

  task automatic tick_n(input int n, input bit nt);
    for (int i = 0; i < n; i++) begin
      cyc(0, '0, nt);
      cyc(0, '0, nt);
      cyc(0, '0, nt);
      cyc(1, '0, nt);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst", obs(), {19'd0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1});
    reset_n = 1'b1;
  endtask

  initial begin
    bit found;
    model_reset();
    do_reset();

    // base cycle: 2 ticks all-red, then dir0/dir1 each 2+15+3+2
    tick_n(2, 0);
    check("rgelb0", {dir, rt[0], ge[0], gr[0]}, 4'b0110);
    tick_n(44, 0);
    check("cycle44", {dir, rt[0], ge[0], gr[0]}, 4'b0110);
    check("glen0", glen[0], TG);
    check("glen1", glen[1], TG);

    // request on dir0 after 3 green ticks: green total 3+5
    tick_n(2, 0);
    tick_n(3, 0);
    cyc(0, 2'b01, 0);
    check("sg0set", f_sg[0], 1);
    tick_n(5, 0);
    check("glen0s", glen[0], 8);
    check("gelb0", {rt[0], ge[0], gr[0]}, 3'b010);
    tick_n(7, 0);
    check("fgr0", {gr[1], f_gr[0], f_sg[0]}, 3'b110);

    // request during dir1 red+yellow: dir1 green enters shortened
    tick_n(42, 0);
    check("rgelb1", {dir, rt[1], ge[1]}, 3'b111);
    cyc(0, 2'b10, 0);
    check("sg1set", f_sg[1], 1);
    tick_n(7, 0);
    check("glen1s", glen[1], TF);

    // request on the final green tick: this green stays full length
    tick_n(7, 0);
    tick_n(14, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    cyc(1, 2'b01, 0);
    check("glen0l", glen[0], TG);
    check("sg0late", f_sg[0], 1);

    // random ticks, requests and night requests
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 2) == 0,
          ($urandom_range(0, 15) == 0) ? N'($urandom) : '0,
          $urandom_range(0, 63) == 0);
    end

    // async reset in the middle of a yellow with both requests pending
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_ph != 4 && ge[dir] && !rt[dir]) found = 1;
      else cyc($urandom_range(0, 1), '0, 0);
    end
    check("findgelb", 32'(found), 1);
    if (found) begin
      cyc(0, 2'b11, 0);
      check("req11", f_sg, 2'b11);
    end
    #2 reset_n = 1'b0;
    #1 check("arst", obs(), {19'd0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1});
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick_n(2, 0);
    check("rgelb0r", {dir, rt[0], ge[0], f_sg}, 5'b01100);

`ifdef AMPEL_NACHT_EN
    tick_n(2, 0);
    tick_n(5, 1);
    tick_n(15, 1);
    check("nacht1", {rt, ge, gr, f_rt, f_gr, f_sg}, 12'b00_11_00_00_00_00);
    tick_n(1, 1);
    check("nacht0", {rt, ge, gr, f_rt, f_gr, f_sg}, 12'b00_00_00_00_00_00);
    tick_n(1, 1);
    check("nacht2", ge, 2'b11);
    tick_n(1, 0);
    check("nexit", {dir, rt, ge, gr}, 7'b1_11_00_00);
    tick_n(2, 0);
    check("nrgelb", {dir, rt[0], ge[0], gr[0]}, 4'b0110);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
